// File: rtl/arb_req_queue_pkg.sv
// Shared constants and types for the arbiter request queue.
package arb_pkg;

    localparam int NPORT = 2;

    // Grant encodings as driven by the downstream 2-port arbiter.
    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_P0   = 2'b01;
    localparam logic [1:0] GNT_P1   = 2'b10;
    localparam logic [1:0] GNT_BAD  = 2'b11;

    typedef logic port_idx_t;

endpackage

// File: rtl/arb_req_queue_if.sv
// Bus bundle between the request sources, the arbiter and the queue block.
//
// Handshake: a push on port i happens at a rising clk edge when in_valid[i]
// and in_ready[i] are both high. in_ready depends only on registered state
// and rst, never on in_valid. out_valid is a one-cycle strobe with no
// backpressure: the consumer must take each issued transaction as it appears.
interface arb_req_queue_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
);
    import arb_pkg::*;

    localparam int OCC_W = $clog2(DEPTH) + 1;

    logic [NPORT-1:0]        in_valid;
    logic [NPORT-1:0]        in_ready;
    logic [NPORT*DATA_W-1:0] in_data;
    logic [NPORT-1:0]        request;
    logic [1:0]              grant;
    logic                    out_valid;
    port_idx_t               out_port;
    logic [DATA_W-1:0]       out_data;
    logic [NPORT*OCC_W-1:0]  occ;
    logic                    err;

    // Sources and arbiter side.
    modport master (
        output in_valid, in_data, grant,
        input  in_ready, request, out_valid, out_port, out_data, occ, err
    );

    // Queue block side.
    modport slave (
        input  in_valid, in_data, grant,
        output in_ready, request, out_valid, out_port, out_data, occ, err
    );

endinterface

// File: rtl/arb_req_fifo.sv
// Single-port synchronous FIFO holding the pending requests of one source.
module arb_req_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int AW     = $clog2(DEPTH),
    parameter int OCC_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty,
    output logic [OCC_W-1:0]  occ
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    // Full/empty come from the registered count, so a pop never makes room
    // for a push in the same cycle.
    assign full    = (occ == OCC_W'(DEPTH));
    assign empty   = (occ == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // Storage array; contents need no reset because occ gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally modulo DEPTH; occ tracks the fill level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: rtl/arb_req_queue.sv
// Two per-source request queues feeding a 2-port arbiter; granted heads are
// issued as one tagged stream and protocol violations raise a sticky error.
module arb_req_queue
    import arb_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input logic              clk,
    input logic              rst,
    arb_req_queue_if.slave   bus
);

    localparam int OCC_W = $clog2(DEPTH) + 1;

    logic [NPORT-1:0]  full;
    logic [NPORT-1:0]  empty;
    logic [NPORT-1:0]  push;
    logic [NPORT-1:0]  pop;
    logic [NPORT-1:0]  overflow;
    logic [DATA_W-1:0] head  [NPORT];
    logic [OCC_W-1:0]  occ_p [NPORT];
    logic              gnt_err;
    logic              issue;
    port_idx_t         issue_port;

    for (genvar i = 0; i < NPORT; i++) begin : g_port
        arb_req_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .push      (push[i]),
            .push_data (bus.in_data[i*DATA_W +: DATA_W]),
            .pop       (pop[i]),
            .head      (head[i]),
            .full      (full[i]),
            .empty     (empty[i]),
            .occ       (occ_p[i])
        );
        assign bus.occ[i*OCC_W +: OCC_W] = occ_p[i];
    end

    assign bus.in_ready = {NPORT{~rst}} & ~full;
    assign push         = bus.in_valid & bus.in_ready;
    assign overflow     = bus.in_valid & ~bus.in_ready & {NPORT{~rst}};
    assign bus.request  = ~empty;

    // Grant decode: only a one-hot grant to a non-empty queue pops; a grant
    // into a queue that is empty in registered state is an error even if a
    // push lands in the same cycle.
    always_comb begin
        pop     = '0;
        gnt_err = 1'b0;
        case (bus.grant)
            GNT_P0: begin
                if (empty[0]) gnt_err = 1'b1;
                else          pop[0]  = 1'b1;
            end
            GNT_P1: begin
                if (empty[1]) gnt_err = 1'b1;
                else          pop[1]  = 1'b1;
            end
            GNT_BAD: gnt_err = 1'b1;
            default: gnt_err = 1'b0;
        endcase
    end

    assign issue      = |pop;
    assign issue_port = pop[1];

    // Issue register: one-cycle strobe, payload and tag held between issues.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_port  <= 1'b0;
            bus.out_data  <= '0;
        end else begin
            bus.out_valid <= issue;
            if (issue) begin
                bus.out_port <= issue_port;
                bus.out_data <= head[issue_port];
            end
        end
    end

    // Sticky protocol-error flag, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.err <= 1'b0;
        end else if (gnt_err || (|overflow)) begin
            bus.err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_arb_req_queue.sv
// Directed bench for arb_req_queue with a queue-based reference model that is
// compared against the DUT on every falling clk edge.
module tb_arb_req_queue;
    import arb_pkg::*;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int OCC_W  = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    arb_req_queue_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    arb_req_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [DATA_W-1:0] exp_q0[$];
    logic [DATA_W-1:0] exp_q1[$];
    logic              m_out_valid = 1'b0;
    logic              m_out_port  = 1'b0;
    logic [DATA_W-1:0] m_out_data  = '0;
    logic              m_err       = 1'b0;

    always @(posedge clk or posedge rst) begin
        int s0;
        int s1;
        if (rst) begin
            exp_q0.delete();
            exp_q1.delete();
            m_out_valid = 1'b0;
            m_out_port  = 1'b0;
            m_out_data  = '0;
            m_err       = 1'b0;
        end else begin
            s0 = exp_q0.size();
            s1 = exp_q1.size();
            m_out_valid = 1'b0;
            if (bus.in_valid[0] && s0 >= DEPTH) m_err = 1'b1;
            if (bus.in_valid[1] && s1 >= DEPTH) m_err = 1'b1;
            if (bus.grant == 2'b01) begin
                if (s0 == 0) m_err = 1'b1;
                else begin
                    m_out_valid = 1'b1;
                    m_out_port  = 1'b0;
                    m_out_data  = exp_q0.pop_front();
                end
            end else if (bus.grant == 2'b10) begin
                if (s1 == 0) m_err = 1'b1;
                else begin
                    m_out_valid = 1'b1;
                    m_out_port  = 1'b1;
                    m_out_data  = exp_q1.pop_front();
                end
            end else if (bus.grant == 2'b11) begin
                m_err = 1'b1;
            end
            if (bus.in_valid[0] && s0 < DEPTH) exp_q0.push_back(bus.in_data[7:0]);
            if (bus.in_valid[1] && s1 < DEPTH) exp_q1.push_back(bus.in_data[15:8]);
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [1:0] e_ready;
        logic [1:0] e_req;
        e_ready = rst ? 2'b00 : {exp_q1.size() < DEPTH, exp_q0.size() < DEPTH};
        e_req   = {exp_q1.size() != 0, exp_q0.size() != 0};
        check("cyc_in_ready",  32'(bus.in_ready),  32'(e_ready));
        check("cyc_request",   32'(bus.request),   32'(e_req));
        check("cyc_occ",       32'(bus.occ),       32'({OCC_W'(exp_q1.size()), OCC_W'(exp_q0.size())}));
        check("cyc_out_valid", 32'(bus.out_valid), 32'(m_out_valid));
        check("cyc_out_port",  32'(bus.out_port),  32'(m_out_port));
        check("cyc_out_data",  32'(bus.out_data),  32'(m_out_data));
        check("cyc_err",       32'(bus.err),       32'(m_err));
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] valid, input logic [7:0] d1,
                         input logic [7:0] d0, input logic [1:0] gnt);
        bus.in_valid = valid;
        bus.in_data  = {d1, d0};
        bus.grant    = gnt;
    endtask

    task automatic idle();
        drive(2'b00, 8'h00, 8'h00, GNT_NONE);
    endtask

    task automatic reset_dut();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int next0;
        int next1;
        int got0;
        int got1;
        int cyc;
        int max0;
        int max1;
        logic [1:0] v;
        logic [1:0] g;

        idle();
        tick();
        tick();
        check("rst_in_ready", 32'(bus.in_ready), 32'h0);
        check("rst_occ", 32'(bus.occ), 32'h0);
        rst = 1'b0;
        tick();
        check("post_rst_in_ready", 32'(bus.in_ready), 32'h3);

        // 1: asynchronous reset with port0 holding three entries
        for (int i = 1; i <= 3; i++) begin
            drive(2'b01, 8'h00, 8'(i), GNT_NONE);
            tick();
        end
        idle();
        check("t1_occ_before", 32'(bus.occ[OCC_W-1:0]), 32'd3);
        #3;
        rst = 1'b1;
        #1;
        check("t1_async_occ", 32'(bus.occ), 32'h0);
        check("t1_async_request", 32'(bus.request), 32'h0);
        check("t1_async_out_valid", 32'(bus.out_valid), 32'h0);
        check("t1_async_in_ready", 32'(bus.in_ready), 32'h0);
        tick();
        rst = 1'b0;
        tick();

        // 2: single transaction through port0
        drive(2'b01, 8'h00, 8'hA5, GNT_NONE);
        tick();
        idle();
        check("t2_request", 32'(bus.request), 32'h1);
        drive(2'b00, 8'h00, 8'h00, GNT_P0);
        tick();
        idle();
        check("t2_out_valid", 32'(bus.out_valid), 32'h1);
        check("t2_out_port", 32'(bus.out_port), 32'h0);
        check("t2_out_data", 32'(bus.out_data), 32'hA5);
        check("t2_request_drop", 32'(bus.request), 32'h0);
        check("t2_err", 32'(bus.err), 32'h0);
        tick();
        check("t2_out_valid_drop", 32'(bus.out_valid), 32'h0);
        check("t2_data_hold", 32'(bus.out_data), 32'hA5);

        // 3: fill port1, overflow, drain in order
        for (int i = 0; i < 4; i++) begin
            drive(2'b10, 8'(8'h10 + i), 8'h00, GNT_NONE);
            tick();
        end
        idle();
        check("t3_in_ready1", 32'(bus.in_ready[1]), 32'h0);
        check("t3_occ1_full", 32'(bus.occ[2*OCC_W-1:OCC_W]), 32'd4);
        drive(2'b10, 8'h14, 8'h00, GNT_NONE);
        tick();
        idle();
        check("t3_overflow_err", 32'(bus.err), 32'h1);
        check("t3_occ1_after_drop", 32'(bus.occ[2*OCC_W-1:OCC_W]), 32'd4);
        for (int i = 0; i < 4; i++) begin
            drive(2'b00, 8'h00, 8'h00, GNT_P1);
            tick();
            check("t3_drain_valid", 32'(bus.out_valid), 32'h1);
            check("t3_drain_port", 32'(bus.out_port), 32'h1);
            check("t3_drain_data", 32'(bus.out_data), 32'(8'h10 + i));
        end
        idle();
        check("t3_request1_drop", 32'(bus.request[1]), 32'h0);
        reset_dut();

        // 4: double grant with both ports loaded
        drive(2'b11, 8'h22, 8'h21, GNT_NONE);
        tick();
        drive(2'b00, 8'h00, 8'h00, GNT_BAD);
        tick();
        idle();
        check("t4_err", 32'(bus.err), 32'h1);
        check("t4_out_valid", 32'(bus.out_valid), 32'h0);
        check("t4_occ", 32'(bus.occ), 32'({OCC_W'(1), OCC_W'(1)}));
        reset_dut();

        // 5: grant to an empty port
        drive(2'b00, 8'h00, 8'h00, GNT_P1);
        tick();
        idle();
        check("t5_err", 32'(bus.err), 32'h1);
        check("t5_out_valid", 32'(bus.out_valid), 32'h0);
        reset_dut();

        // 5b: push into empty port with same-cycle grant is a grant to empty
        drive(2'b01, 8'h00, 8'h77, GNT_P0);
        tick();
        idle();
        check("t5b_err", 32'(bus.err), 32'h1);
        check("t5b_out_valid", 32'(bus.out_valid), 32'h0);
        check("t5b_occ0", 32'(bus.occ[OCC_W-1:0]), 32'd1);
        reset_dut();

        // 6: wrap and interleave with random grant gaps
        next0 = 0; next1 = 0; got0 = 0; got1 = 0; cyc = 0; max0 = 0; max1 = 0;
        while ((got0 < 10 || got1 < 10) && cyc < 400) begin
            v[0] = (next0 < 10) && bus.in_ready[0];
            v[1] = (next1 < 10) && (cyc % 2 == 0) && bus.in_ready[1];
            g = GNT_NONE;
            if ($urandom_range(0, 2) != 0) begin
                if (bus.request == 2'b11) g = ($urandom_range(0, 1) == 0) ? GNT_P0 : GNT_P1;
                else if (bus.request == 2'b01) g = GNT_P0;
                else if (bus.request == 2'b10) g = GNT_P1;
            end
            drive(v, 8'(8'h80 + next1), 8'(next0), g);
            tick();
            if (v[0]) next0++;
            if (v[1]) next1++;
            if (int'(bus.occ[OCC_W-1:0]) > max0) max0 = int'(bus.occ[OCC_W-1:0]);
            if (int'(bus.occ[2*OCC_W-1:OCC_W]) > max1) max1 = int'(bus.occ[2*OCC_W-1:OCC_W]);
            if (bus.out_valid) begin
                if (bus.out_port == 1'b0) begin
                    check("t6_port0_order", 32'(bus.out_data), 32'(got0));
                    got0++;
                end else begin
                    check("t6_port1_order", 32'(bus.out_data), 32'(8'h80 + got1));
                    got1++;
                end
            end
            cyc++;
        end
        idle();
        check("t6_stream_done", 32'((got0 == 10) && (got1 == 10)), 32'h1);
        check("t6_max_occ", 32'((max0 <= DEPTH) && (max1 <= DEPTH)), 32'h1);
        check("t6_err", 32'(bus.err), 32'h0);
        tick();
        tick();

        // ---------------- final report ----------------
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
